noise_channel_ctrl: RTL and testbench

- Control and register front end for the 4-channel audio noise generator.
- Owns the NR41–NR44 register file, trigger handling, length counter and volume envelope.
- Drives NR43 and an LFSR reload pulse into the noise generator, and takes back its 1-bit LFSR output.
- Produces the gated, volume-scaled noise sample for the mixer.

---
 rtl/noise_channel_ctrl_if.sv | 25 ++
 rtl/noise_channel_ctrl.sv | 136 +++++++++++++
 tb/tb_noise_channel_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/noise_channel_ctrl_if.sv
// Register-bus interface for the noise channel front end: write strobe/address/data
// plus a combinational read port.
interface noise_channel_ctrl_if;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/noise_channel_ctrl.sv
// Noise channel control: NR41-NR44 registers, trigger, length counter, envelope, sample gate.
// Optional NOISE_CTRL_LEN_EXTRA_CLOCK_EN: extra length clock when len_en rises on an odd step.
module noise_channel_ctrl #(
    parameter int unsigned LEN_MAX         = 64,
    parameter int unsigned ENV_ZERO_PERIOD = 8
) (
    input  logic                 system_clock,
    input  logic                 reset,
    input  logic                 apu_enable,
    noise_channel_ctrl_if.slave  bus,
    input  logic                 frame_tick,
    input  logic                 lfsr_bit,
    output logic [7:0]           NR43,
    output logic                 lfsr_reload,
    output logic                 channel_on,
    output logic [3:0]           volume,
    output logic [3:0]           sample
);
    localparam int unsigned LEN_W = $clog2(LEN_MAX + 1);
    localparam int unsigned ENV_W = $clog2(ENV_ZERO_PERIOD + 1);
    localparam logic [LEN_W-1:0] LEN_LOAD = LEN_W'(LEN_MAX);
    localparam logic [ENV_W-1:0] ENV_LOAD = ENV_W'(ENV_ZERO_PERIOD);

    logic [7:0]       nr42;
    logic             len_en;
    logic [LEN_W-1:0] length_counter;
    logic [ENV_W-1:0] env_timer;
    logic [2:0]       step;

    logic             wr_nr41, wr_nr42, wr_nr43, wr_nr44, trigger;
    logic             dac_on, len_clk, env_clk, extra_clk;
    logic [ENV_W-1:0] env_period;
    logic [LEN_W-1:0] len_n;
    logic [ENV_W-1:0] tmr_n;
    logic [3:0]       vol_n;
    logic             ch_n;

    always_comb begin
        unique case (bus.rd_addr)
            2'd0:    bus.rd_data = 8'hFF;
            2'd1:    bus.rd_data = nr42;
            2'd2:    bus.rd_data = NR43;
            default: bus.rd_data = {1'b1, len_en, 6'h3F};
        endcase
    end

    always_comb begin
        wr_nr41    = bus.wr_en && (bus.wr_addr == 2'd0);
        wr_nr42    = bus.wr_en && (bus.wr_addr == 2'd1);
        wr_nr43    = bus.wr_en && (bus.wr_addr == 2'd2);
        wr_nr44    = bus.wr_en && (bus.wr_addr == 2'd3);
        trigger    = wr_nr44 && bus.wr_data[7];
        dac_on     = |nr42[7:3];
        len_clk    = frame_tick && !step[0];
        env_clk    = frame_tick && (step == 3'd7) && (|nr42[2:0]);
        env_period = (nr42[2:0] == 3'd0) ? ENV_LOAD : ENV_W'(nr42[2:0]);
`ifdef NOISE_CTRL_LEN_EXTRA_CLOCK_EN
        extra_clk  = wr_nr44 && bus.wr_data[6] && !len_en && step[0];
`else
        extra_clk  = 1'b0;
`endif

        len_n = length_counter;
        ch_n  = channel_on;
        vol_n = volume;
        tmr_n = env_timer;

        // Writes and triggers take precedence over the frame-sequencer length clock;
        // the extra clock is applied before the trigger reload so a reload lands at LEN_MAX-1.
        if (wr_nr41) begin
            len_n = LEN_LOAD - LEN_W'(bus.wr_data[5:0]);
        end else if (trigger || extra_clk) begin
            if (extra_clk && (length_counter != '0)) begin
                len_n = length_counter - LEN_W'(1);
                if ((len_n == '0) && !trigger)
                    ch_n = 1'b0;
            end
            if (trigger) begin
                ch_n = dac_on;
                if (len_n == '0)
                    len_n = extra_clk ? (LEN_LOAD - LEN_W'(1)) : LEN_LOAD;
            end
        end else if (len_clk && len_en && (length_counter != '0)) begin
            len_n = length_counter - LEN_W'(1);
            if (len_n == '0)
                ch_n = 1'b0;
        end

        if (wr_nr42 && (bus.wr_data[7:3] == 5'd0))
            ch_n = 1'b0;

        if (trigger) begin
            vol_n = nr42[7:4];
            tmr_n = env_period;
        end else if (env_clk) begin
            if (env_timer > ENV_W'(1)) begin
                tmr_n = env_timer - ENV_W'(1);
            end else begin
                tmr_n = env_period;
                if (nr42[3] && (volume != 4'hF))
                    vol_n = volume + 4'd1;
                else if (!nr42[3] && (volume != 4'h0))
                    vol_n = volume - 4'd1;
            end
        end
    end

    always_ff @(posedge system_clock) begin
        if (!reset || !apu_enable) begin
            nr42           <= '0;
            NR43           <= '0;
            len_en         <= 1'b0;
            length_counter <= '0;
            env_timer      <= '0;
            volume         <= '0;
            step           <= '0;
            channel_on     <= 1'b0;
            lfsr_reload    <= 1'b0;
            sample         <= '0;
        end else begin
            if (wr_nr42)
                nr42 <= bus.wr_data;
            if (wr_nr43)
                NR43 <= bus.wr_data;
            if (wr_nr44)
                len_en <= bus.wr_data[6];
            length_counter <= len_n;
            env_timer      <= tmr_n;
            volume         <= vol_n;
            channel_on     <= ch_n;
            step           <= step + {2'b00, frame_tick};
            lfsr_reload    <= trigger;
            sample         <= (channel_on && lfsr_bit) ? volume : '0;
        end
    end
endmodule

// File: tb/tb_noise_channel_ctrl.sv
// Self-checking bench for noise_channel_ctrl: vector table with scoreboard queue plus
// hand-written sequences for reset, envelope, DAC-off, gating and collision cases.
module tb_noise_channel_ctrl;
    logic       system_clock = 1'b0;
    logic       reset;
    logic       apu_enable;
    logic       frame_tick;
    logic       lfsr_bit;
    logic [7:0] NR43;
    logic       lfsr_reload;
    logic       channel_on;
    logic [3:0] volume;
    logic [3:0] sample;

    noise_channel_ctrl_if bus ();

    noise_channel_ctrl #(
        .LEN_MAX        (64),
        .ENV_ZERO_PERIOD(8)
    ) dut (
        .system_clock(system_clock),
        .reset       (reset),
        .apu_enable  (apu_enable),
        .bus         (bus.slave),
        .frame_tick  (frame_tick),
        .lfsr_bit    (lfsr_bit),
        .NR43        (NR43),
        .lfsr_reload (lfsr_reload),
        .channel_on  (channel_on),
        .volume      (volume),
        .sample      (sample)
    );

    always #5 system_clock = ~system_clock;

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] data;
        logic       ft;
        logic       lb;
        logic       e_on;
        logic [6:0] e_len;
        logic [3:0] e_vol;
        logic [3:0] e_smp;
        logic       e_rel;
    } vec_t;

    vec_t       vecs[12];
    vec_t       sb[$];
    logic [3:0] smp_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge system_clock);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step_cycle();
        bus.wr_en   = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step_cycle();
        frame_tick = 1'b0;
        step_cycle();
    endtask

    task automatic clear_apu();
        apu_enable = 1'b0;
        step_cycle();
        check("apu_off_channel_on", int'(channel_on), 0);
        check("apu_off_len", int'(dut.length_counter), 0);
        apu_enable = 1'b1;
    endtask

    initial begin
        vec_t v;
        logic [3:0] pat;

        // length-expiry table: {we, addr, data, ft, lb, on, len, vol, sample, reload}
        vecs[0]  = '{1'b1, 2'd1, 8'hF0, 1'b0, 1'b1, 1'b0, 7'd0, 4'h0, 4'h0, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 8'h3C, 1'b0, 1'b1, 1'b0, 7'd4, 4'h0, 4'h0, 1'b0};
        vecs[2]  = '{1'b1, 2'd3, 8'hC0, 1'b0, 1'b1, 1'b1, 7'd4, 4'hF, 4'h0, 1'b1};
        vecs[3]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1, 7'd3, 4'hF, 4'hF, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1, 7'd3, 4'hF, 4'hF, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1, 7'd2, 4'hF, 4'hF, 1'b0};
        vecs[6]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1, 7'd2, 4'hF, 4'hF, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1, 7'd1, 4'hF, 4'hF, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1, 7'd1, 4'hF, 4'hF, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 7'd0, 4'hF, 4'hF, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 7'd0, 4'hF, 4'h0, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 7'd0, 4'hF, 4'h0, 1'b0};

        // reset held for two cycles with writes pending
        reset       = 1'b0;
        apu_enable  = 1'b1;
        frame_tick  = 1'b0;
        lfsr_bit    = 1'b1;
        bus.rd_addr = 2'd3;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd3;
        bus.wr_data = 8'hC0;
        for (int i = 0; i < 2; i++) begin
            step_cycle();
            check("rst_channel_on", int'(channel_on), 0);
            check("rst_volume", int'(volume), 0);
            check("rst_sample", int'(sample), 0);
            check("rst_nr43", int'(NR43), 0);
            check("rst_lfsr_reload", int'(lfsr_reload), 0);
            check("rst_rd_nr44", int'(bus.rd_data), 8'hBF);
            bus.wr_addr = 2'd2;
            bus.wr_data = 8'h5A;
        end
        bus.wr_en = 1'b0;
        reset     = 1'b1;

        // table-driven length expiry, step starts at 0
        for (int i = 0; i < 12; i++) begin
            bus.wr_en   = vecs[i].we;
            bus.wr_addr = vecs[i].addr;
            bus.wr_data = vecs[i].data;
            frame_tick  = vecs[i].ft;
            lfsr_bit    = vecs[i].lb;
            sb.push_back(vecs[i]);
            step_cycle();
            v = sb.pop_front();
            check($sformatf("len_vec%0d_on", i), int'(channel_on), int'(v.e_on));
            check($sformatf("len_vec%0d_len", i), int'(dut.length_counter), int'(v.e_len));
            check($sformatf("len_vec%0d_vol", i), int'(volume), int'(v.e_vol));
            check($sformatf("len_vec%0d_smp", i), int'(sample), int'(v.e_smp));
            check($sformatf("len_vec%0d_rel", i), int'(lfsr_reload), int'(v.e_rel));
        end
        bus.wr_en  = 1'b0;
        frame_tick = 1'b0;

        // register readback
        do_write(2'd2, 8'h5A);
        check("nr43_port", int'(NR43), 8'h5A);
        bus.rd_addr = 2'd2; #1;
        check("rd_nr43", int'(bus.rd_data), 8'h5A);
        bus.rd_addr = 2'd0; #1;
        check("rd_nr41", int'(bus.rd_data), 8'hFF);
        bus.rd_addr = 2'd1; #1;
        check("rd_nr42", int'(bus.rd_data), 8'hF0);
        bus.rd_addr = 2'd3; #1;
        check("rd_nr44", int'(bus.rd_data), 8'hFF);

        // writes ignored while APU disabled
        apu_enable = 1'b0;
        do_write(2'd1, 8'h77);
        apu_enable  = 1'b1;
        bus.rd_addr = 2'd1; #1;
        check("apu_off_write_ignored", int'(bus.rd_data), 0);

        // envelope: vol 0, up, period 3
        clear_apu();
        do_write(2'd1, 8'h0B);
        do_write(2'd3, 8'h80);
        check("env_trig_on", int'(channel_on), 1);
        check("env_trig_vol", int'(volume), 0);
        for (int g = 0; g < 16; g++) begin
            for (int t = 0; t < 23; t++) tick();
            check($sformatf("env_g%0d_pre", g), int'(volume), (g > 15) ? 15 : g);
            tick();
            check($sformatf("env_g%0d_post", g), int'(volume), (g + 1 > 15) ? 15 : g + 1);
        end

        // DAC off
        clear_apu();
        do_write(2'd1, 8'hF0);
        do_write(2'd3, 8'h80);
        check("dac_run_on", int'(channel_on), 1);
        do_write(2'd1, 8'h00);
        check("dac_off_on", int'(channel_on), 0);
        do_write(2'd3, 8'h80);
        check("dac_off_trig_on", int'(channel_on), 0);
        check("dac_off_trig_reload", int'(lfsr_reload), 1);
        step_cycle();
        check("dac_off_reload_pulse", int'(lfsr_reload), 0);

        // sample gating through the scoreboard queue
        clear_apu();
        lfsr_bit = 1'b0;
        do_write(2'd1, 8'hA0);
        do_write(2'd3, 8'h80);
        check("gate_trig_smp", int'(sample), 0);
        pat = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            lfsr_bit = pat[i];
            smp_q.push_back(pat[i] ? 4'hA : 4'h0);
            step_cycle();
            check($sformatf("gate_smp%0d", i), int'(sample), int'(smp_q.pop_front()));
        end

        // NR41 write beats a length clock; extra clock on odd step
        clear_apu();
        do_write(2'd0, 8'h3C);
        do_write(2'd3, 8'h40);
        check("coll_pre_len", int'(dut.length_counter), 4);
        frame_tick = 1'b1;
        do_write(2'd0, 8'h00);
        frame_tick = 1'b0;
        check("coll_len", int'(dut.length_counter), 64);
        do_write(2'd3, 8'h00);
        do_write(2'd3, 8'h40);
`ifdef NOISE_CTRL_LEN_EXTRA_CLOCK_EN
        check("extra_clk_len", int'(dut.length_counter), 63);
`else
        check("extra_clk_len", int'(dut.length_counter), 64);
`endif

        // reset mid-operation with a trigger pending
        do_write(2'd1, 8'hF0);
        do_write(2'd3, 8'h80);
        check("mid_pre_on", int'(channel_on), 1);
        reset       = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd3;
        bus.wr_data = 8'h80;
        step_cycle();
        check("mid_rst_on", int'(channel_on), 0);
        check("mid_rst_vol", int'(volume), 0);
        check("mid_rst_reload", int'(lfsr_reload), 0);
        check("mid_rst_nr43", int'(NR43), 0);
        bus.wr_en = 1'b0;
        reset     = 1'b1;
        step_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
